// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
// Brings the board PLL out of reset, waits for lock with a timeout, qualifies
// the lock as stable and only then releases the downstream system reset.
// Any loss of lock in RUN, or a forced relock, restarts the whole sequence.
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 64,
  parameter int SYNC_STAGES         = 2,
  parameter int CNT_W               = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] retry_count
);

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Terminal counts: each phase ends when the counter reaches its last value.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   lk;
  logic                   lock_lost_next;
  logic                   retry_inc;
  logic [7:0]             retry_reg, retry_next;
  logic                   pll_rst_reg, sys_reset_reg, ready_reg, lock_lost_reg;

  // pll_locked is asynchronous to refclk; shift it through a plain flop chain.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pll_locked};
    end
  end

  // Only the last synchroniser stage is ever looked at by the FSM.
  assign lk = sync_reg[SYNC_STAGES-1];

  // Next-state, counter and event decode; a forced relock overrides everything
  // except an already-running reset pulse, which is allowed to complete.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    lock_lost_next = 1'b0;
    retry_inc      = 1'b0;

    if (force_relock && (state_reg != PLL_RST)) begin
      state_next = PLL_RST;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        PLL_RST: begin
          if (cnt_reg == RST_LAST) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lk) begin
            state_next = STABLE;
            cnt_next   = '0;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            state_next = PLL_RST;
            cnt_next   = '0;
            retry_inc  = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        STABLE: begin
          // A dropout while qualifying is treated as a glitch, not a retry.
          if (!lk) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else if (cnt_reg == STABLE_LAST) begin
            state_next = RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        RUN: begin
          if (!lk) begin
            state_next     = PLL_RST;
            cnt_next       = '0;
            lock_lost_next = 1'b1;
            retry_inc      = 1'b1;
          end
        end
        default: begin
          state_next = PLL_RST;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // The retry counter sticks at its maximum rather than wrapping.
  always_comb begin
    retry_next = retry_reg;
    if (retry_inc && (retry_reg != 8'hFF)) begin
      retry_next = retry_reg + 8'd1;
    end
  end

  // State and counter registers.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_reg <= PLL_RST;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state register, with no extra cycle of lag.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      pll_rst_reg   <= 1'b1;
      sys_reset_reg <= 1'b1;
      ready_reg     <= 1'b0;
      lock_lost_reg <= 1'b0;
      retry_reg     <= 8'd0;
    end else begin
      pll_rst_reg   <= (state_next == PLL_RST);
      sys_reset_reg <= (state_next != RUN);
      ready_reg     <= (state_next == RUN);
      lock_lost_reg <= lock_lost_next;
      retry_reg     <= retry_next;
    end
  end

  assign pll_rst     = pll_rst_reg;
  assign sys_reset   = sys_reset_reg;
  assign ready       = ready_reg;
  assign lock_lost   = lock_lost_reg;
  assign retry_count = retry_reg;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: a phase/dwell-time model of the lock sequence
// is advanced on every refclk edge and compared against all outputs on the
// following falling edge, plus a few hand-derived literal checkpoints.
module tb_pll_lock_sequencer;

  localparam int RSTP = 4;
  localparam int TO   = 32;
  localparam int STB  = 8;
  localparam int SYNC = 2;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       force_relock = 1'b0;
  logic       pll_rst, sys_reset, ready, lock_lost;
  logic [7:0] retry_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: phase 0=reset pulse, 1=waiting, 2=qualifying, 3=running.
  int m_phase;
  int m_start;
  int m_edges = 0;
  int m_retry;
  bit m_ll;
  bit m_hist[SYNC];

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES(RSTP), .LOCK_TIMEOUT_CYCLES(TO), .LOCK_STABLE_CYCLES(STB),
    .SYNC_STAGES(SYNC), .CNT_W(16)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .force_relock(force_relock),
    .pll_rst(pll_rst), .sys_reset(sys_reset), .ready(ready), .lock_lost(lock_lost),
    .retry_count(retry_count)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_start = m_edges;
    m_retry = 0;
    m_ll    = 1'b0;
    for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b0;
  endtask

  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  // Apply one edge of the sequencing rules; dwell = cycles spent in the phase
  // including the one ending at this edge.
  task automatic model_edge(input bit pin, input bit frc);
    bit lk_seen;
    int dwell;
    m_edges++;
    lk_seen = m_hist[SYNC-1];
    dwell   = m_edges - m_start;
    for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = pin;
    m_ll = 1'b0;
    if (frc && m_phase != 0) begin
      m_phase = 0; m_start = m_edges;
    end else if (m_phase == 0) begin
      if (dwell == RSTP) begin m_phase = 1; m_start = m_edges; end
    end else if (m_phase == 1) begin
      if (lk_seen) begin m_phase = 2; m_start = m_edges; end
      else if (dwell == TO) begin m_phase = 0; m_start = m_edges; m_retry = sat_inc(m_retry); end
    end else if (m_phase == 2) begin
      if (!lk_seen) begin m_phase = 1; m_start = m_edges; end
      else if (dwell == STB) m_phase = 3;
    end else begin
      if (!lk_seen) begin
        m_phase = 0; m_start = m_edges; m_ll = 1'b1; m_retry = sat_inc(m_retry);
      end
    end
  endtask

  task automatic compare_all();
    check("pll_rst",     int'(pll_rst),   int'(m_phase == 0));
    check("sys_reset",   int'(sys_reset), int'(m_phase != 3));
    check("ready",       int'(ready),     int'(m_phase == 3));
    check("lock_lost",   int'(lock_lost), int'(m_ll));
    check("retry_count", int'(retry_count), m_retry);
  endtask

  // One refclk cycle: model follows the edge, outputs compared on the falling edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge refclk);
      model_edge(pll_locked, force_relock);
      @(negedge refclk);
      compare_all();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge refclk);
    @(negedge refclk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int run_len;
    model_reset();

    // Bring-up: pin seen high at edge 10 -> ready from cycle 20.
    do_reset();
    check("reset_pll_rst", int'(pll_rst), 1);
    check("reset_ready", int'(ready), 0);
    check("reset_retry", int'(retry_count), 0);
    for (int c = 1; c <= 22; c++) begin
      step(1);
      if (c == 9) pll_locked = 1'b1;
      if (c == 3)  check("pll_rst_c3", int'(pll_rst), 1);
      if (c == 4)  check("pll_rst_c4", int'(pll_rst), 0);
      if (c == 19) check("ready_c19", int'(ready), 0);
      if (c == 20) check("ready_c20", int'(ready), 1);
      if (c == 20) check("sysrst_c20", int'(sys_reset), 0);
    end

    // Lock loss in RUN: pulse appears once the drop has crossed the synchroniser.
    pll_locked = 1'b0;
    step(2);
    check("ll_early", int'(lock_lost), 0);
    step(1);
    check("ll_pulse", int'(lock_lost), 1);
    check("ll_sysrst", int'(sys_reset), 1);
    check("ll_retry", int'(retry_count), 1);
    step(1);
    check("ll_one_cycle", int'(lock_lost), 0);

    // Relock, then a forced relock pulse from RUN.
    pll_locked = 1'b1;
    step(30);
    check("relock_ready", int'(ready), 1);
    force_relock = 1'b1;
    step(1);
    force_relock = 1'b0;
    check("force_pll_rst", int'(pll_rst), 1);
    check("force_no_ll", int'(lock_lost), 0);
    check("force_retry", int'(retry_count), 1);

    // One-cycle glitch while qualifying lock; retry count must not move.
    step(7);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(30);
    check("glitch_ready", int'(ready), 1);
    check("glitch_retry", int'(retry_count), 1);

    // Asynchronous reset in the middle of STABLE.
    force_relock = 1'b1;
    step(1);
    force_relock = 1'b0;
    step(7);
    #2 rst = 1'b1;
    #1;
    check("async_pll_rst", int'(pll_rst), 1);
    check("async_sysrst", int'(sys_reset), 1);
    check("async_ready", int'(ready), 0);
    check("async_retry", int'(retry_count), 0);
    do_reset();

    // First timeout lands after RSTP+TO cycles.
    pll_locked = 1'b0;
    step(35);
    check("to_before", int'(retry_count), 0);
    step(1);
    check("to_retry", int'(retry_count), 1);
    check("to_pll_rst", int'(pll_rst), 1);

    // Randomised pin activity and sporadic forced relocks.
    run_len = 0;
    for (int k = 0; k < 4000; k++) begin
      if (run_len == 0) begin
        pll_locked = 1'($urandom_range(0, 1));
        run_len = int'($urandom_range(1, 70));
      end
      run_len--;
      force_relock = ($urandom_range(0, 63) == 0);
      step(1);
    end
    force_relock = 1'b0;

    // Saturation of the retry counter under a permanently unlocked PLL.
    do_reset();
    pll_locked = 1'b0;
    step(255 * (RSTP + TO));
    check("sat_255", int'(retry_count), 255);
    step(2 * (RSTP + TO));
    check("sat_hold", int'(retry_count), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
